// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: state encodings and shared constants for the I2C slave byte engines.
package i2c_slave_pkg;
  localparam int BIT_INDEX_W = 3;
  localparam int DEFAULT_HOLD_CYCLES = 4;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_DRIVEN,
    ST_RELEASE
  } write_state_e;
endpackage

// File: rtl/i2c_slave_write_bit.sv
// i2c_slave_write_bit: owns the SDA register and the tHD;DAT hold counter for one bit.
// A start arms a value that lands on SDA after HOLD_CYCLES, or at once on an early SCL rise.
module i2c_slave_write_bit #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic start,
  input  logic bit_val,
  input  logic rise,
  output logic expire,
  output logic sda_out
);
  logic [7:0] cnt_q, cnt_d;
  logic pending_q, pending_d;
  logic val_q, val_d;
  logic sda_q, sda_d;
  logic apply;
  always_comb begin
    expire = pending_q & (cnt_q <= 8'd1);
    apply = pending_q & (rise | (cnt_q <= 8'd1));
    cnt_d = start ? 8'(HOLD_CYCLES) : (pending_q ? cnt_q - 8'd1 : cnt_q);
    val_d = start ? bit_val : val_q;
    pending_d = clear ? 1'b0 : (start ? (HOLD_CYCLES != 0) : (pending_q & ~apply));
    sda_d = clear ? 1'b1 : ((start && HOLD_CYCLES == 0) ? bit_val : (apply ? val_q : sda_q));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 8'd0;
      pending_q <= 1'b0;
      val_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      pending_q <= pending_d;
      val_q <= val_d;
      sda_q <= sda_d;
    end
  end
  assign sda_out = sda_q;
endmodule

// File: rtl/i2c_slave_write_byte.sv
// i2c_slave_write_byte: slave-side I2C transmitter, shifts one byte MSB-first onto SDA.
// Define I2C_SLAVE_WRITE_READBACK_CHECK_EN to abandon the byte when SDA reads low against a released bit.
module i2c_slave_write_byte
  import i2c_slave_pkg::*;
#(
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       abort,
  input  logic [7:0] data,
  output logic       busy,
  output logic       error,
  output logic       finish,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out
);
  write_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [BIT_INDEX_W-1:0] idx_q, idx_d;
  logic scl_last_q, busy_q, busy_d, error_q, error_d, finish_q, finish_d;
  logic rise, fall, hold_rise, mismatch;
  logic start, clear, bit_val, expire;
  assign rise = ~scl_last_q & scl;
  assign fall = scl_last_q & ~scl;
  assign hold_rise = rise & (state_q == ST_HOLD);
`ifdef I2C_SLAVE_WRITE_READBACK_CHECK_EN
  assign mismatch = rise & sda_out & ~sda_in;
`else
  logic unused_sda_in;
  assign unused_sda_in = sda_in;
  assign mismatch = 1'b0;
`endif
  i2c_slave_write_bit #(.HOLD_CYCLES(HOLD_CYCLES)) u_bit (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .start(start),
    .bit_val(bit_val),
    .rise(hold_rise),
    .expire(expire),
    .sda_out(sda_out)
  );
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d = idx_q;
    error_d = error_q;
    finish_d = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    bit_val = shift_q[6];
    if (abort) begin
      clear = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (enable && !scl) begin
          shift_d = data;
          idx_d = BIT_INDEX_W'(7);
          error_d = 1'b0;
          start = 1'b1;
          bit_val = data[7];
          state_d = (HOLD_CYCLES == 0) ? ST_DRIVEN : ST_HOLD;
        end
        // an SCL rise before the hold expires is a setup violation: drive now and flag it
        ST_HOLD: if (rise || expire) begin
          error_d = error_q | rise;
          state_d = ST_DRIVEN;
        end
        ST_DRIVEN: if (mismatch) begin
          error_d = 1'b1;
          clear = 1'b1;
          state_d = ST_IDLE;
        end else if (fall) begin
          start = 1'b1;
          if (idx_q != '0) begin
            shift_d = shift_q << 1;
            idx_d = idx_q - BIT_INDEX_W'(1);
            state_d = (HOLD_CYCLES == 0) ? ST_DRIVEN : ST_HOLD;
          end else begin
            finish_d = 1'b1;
            bit_val = 1'b1;
            state_d = (HOLD_CYCLES == 0) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: if (expire) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = state_d != ST_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= 8'd0;
      idx_q <= '0;
      scl_last_q <= 1'b1;
      busy_q <= 1'b0;
      error_q <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      scl_last_q <= scl;
      busy_q <= busy_d;
      error_q <= error_d;
      finish_q <= finish_d;
    end
  end
  assign busy = busy_q;
  assign error = error_q;
  assign finish = finish_q;
endmodule

// File: tb/tb_i2c_slave_write_byte.sv
// tb_i2c_slave_write_byte: randomized SCL waveforms checked cycle by cycle against a bit-slot reference model.
module tb_i2c_slave_write_byte;
  localparam int H = 4;
  localparam int N = 300;
  logic clock = 1'b0;
  logic reset, enable, abort, scl, sda_in, busy, error, finish, sda_out;
  logic [7:0] data;
  always #5 clock = ~clock;
  i2c_slave_write_byte #(.HOLD_CYCLES(H)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .abort(abort),
    .data(data),
    .busy(busy),
    .error(error),
    .finish(finish),
    .scl(scl),
    .sda_in(sda_in),
    .sda_out(sda_out)
  );
  int checks = 0;
  int failures = 0;
  logic scl_s[N], sda_in_s[N], en_s[N], ab_s[N];
  logic [7:0] dat_s;
  logic [3:0] obs[N];
  logic e_sda[N], e_busy[N], e_fin[N], e_err[N];
  int rise_at[9], fall_at[9];
  logic err_now;
  function automatic logic is_rise(input int k);
    return k > 0 && !scl_s[k-1] && scl_s[k];
  endfunction
  function automatic logic is_fall(input int k);
    return k > 0 && scl_s[k-1] && !scl_s[k];
  endfunction
  // enable at cycle 5 with SCL low, then eight data periods plus the ACK period
  task automatic gen(input logic [7:0] d, input int lo_min, input int lo_max, input int hi_min, input int hi_max);
    int c, lo, hi;
    dat_s = d;
    for (int k = 0; k < N; k++) begin
      scl_s[k] = 1'b1;
      sda_in_s[k] = 1'b1;
      en_s[k] = 1'b0;
      ab_s[k] = 1'b0;
    end
    scl_s[3] = 1'b0;
    scl_s[4] = 1'b0;
    en_s[5] = 1'b1;
    c = 5;
    for (int p = 0; p < 9; p++) begin
      lo = int'($urandom_range(lo_max, lo_min));
      hi = int'($urandom_range(hi_max, hi_min));
      for (int j = 0; j < lo; j++) scl_s[c+j] = 1'b0;
      rise_at[p] = c + lo;
      c = c + lo + hi;
      fall_at[p] = c;
    end
  endtask
  task automatic play();
    for (int k = 0; k < N; k++) begin
      @(negedge clock);
      obs[k] = {sda_out, busy, finish, error};
      scl = scl_s[k];
      sda_in = sda_in_s[k];
      enable = en_s[k];
      abort = ab_s[k];
      data = (k == 5) ? dat_s : 8'($urandom);
    end
  endtask
  // Walks the byte bit slot by bit slot: each slot opens at an enable or falling edge,
  // its bit appears H+1 cycles later (or the cycle after an early rise), and it ends at the next fall.
  task automatic model();
    int t, s, d, f, stop;
    logic viol;
    t = -1;
    stop = N;
    for (int k = 0; k < N; k++) begin
      e_sda[k] = 1'b1;
      e_busy[k] = 1'b0;
      e_fin[k] = 1'b0;
      e_err[k] = err_now;
    end
    for (int k = 0; k < N; k++) if (t < 0 && en_s[k] && !scl_s[k]) t = k;
    if (t >= 0) begin
      for (int k = t + 1; k < N; k++) e_err[k] = 1'b0;
      s = t;
      for (int b = 7; b >= 0; b--) begin
        d = s + H + 1;
        viol = 1'b0;
        for (int r = s + H; r > s; r--) if (is_rise(r)) begin
          d = r + 1;
          viol = 1'b1;
        end
        for (int k = d; k < N; k++) begin
          e_sda[k] = dat_s[b];
          if (viol) e_err[k] = 1'b1;
        end
        f = -1;
        for (int k = d; k < N; k++) begin
`ifdef I2C_SLAVE_WRITE_READBACK_CHECK_EN
          if (is_rise(k) && dat_s[b] && !sda_in_s[k]) begin
            for (int j = k + 1; j < N; j++) begin
              e_err[j] = 1'b1;
              e_sda[j] = 1'b1;
            end
            stop = k + 1;
            break;
          end
`endif
          if (is_fall(k)) begin
            f = k;
            break;
          end
        end
        if (f < 0) break;
        s = f;
        if (b == 0) begin
          if (f + 1 < N) e_fin[f+1] = 1'b1;
          stop = f + H + 1;
          for (int k = stop; k < N; k++) e_sda[k] = 1'b1;
        end
      end
      for (int k = t + 1; k < stop && k < N; k++) e_busy[k] = 1'b1;
      for (int a = t; a < stop && a < N; a++) if (ab_s[a]) begin
        for (int k = a + 1; k < N; k++) begin
          e_sda[k] = 1'b1;
          e_busy[k] = 1'b0;
          e_fin[k] = 1'b0;
          e_err[k] = e_err[a];
        end
        break;
      end
    end
    err_now = e_err[N-1];
  endtask
  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    abort = 1'b0;
    scl = 1'b1;
    sda_in = 1'b1;
    data = 8'd0;
    repeat (3) @(negedge clock);
    checks++;
    if ({sda_out, busy, finish, error} !== 4'b1000) begin
      failures++;
      $display("FAIL reset {sda,busy,finish,error} got=%b exp=1000", {sda_out, busy, finish, error});
    end
    reset = 1'b0;
    err_now = 1'b0;
  endtask
  task automatic test_a5();
    logic [7:0] seq;
    int fins;
    seq = 8'hA5;
    fins = 0;
    gen(seq, 10, 10, 10, 10);
    play();
    model();
    for (int k = 0; k < N; k++) begin
      checks++;
      fins += int'(obs[k][1]);
      if (obs[k] !== {e_sda[k], e_busy[k], e_fin[k], e_err[k]}) begin
        failures++;
        $display("FAIL a5 cyc=%0d got=%b exp=%b", k, obs[k], {e_sda[k], e_busy[k], e_fin[k], e_err[k]});
      end
    end
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (obs[rise_at[p]][3] !== seq[7-p]) begin
        failures++;
        $display("FAIL a5_bit%0d sda got=%b exp=%b", 7 - p, obs[rise_at[p]][3], seq[7-p]);
      end
    end
    checks++;
    if (fins != 1) begin
      failures++;
      $display("FAIL a5_finish_count got=%0d exp=1", fins);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      gen(8'($urandom), 6, 12, 3, 10);
      play();
      model();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (obs[k] !== {e_sda[k], e_busy[k], e_fin[k], e_err[k]}) begin
          failures++;
          $display("FAIL random%0d data=%h cyc=%0d got=%b exp=%b", i, dat_s, k, obs[k], {e_sda[k], e_busy[k], e_fin[k], e_err[k]});
        end
      end
    end
  endtask
  task automatic test_enable_scl_high();
    gen(8'h00, 8, 8, 8, 8);
    for (int k = 0; k < N; k++) scl_s[k] = 1'b1;
    en_s[40] = 1'b1;
    en_s[41] = 1'b1;
    play();
    model();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obs[k] !== {e_sda[k], e_busy[k], e_fin[k], e_err[k]} || obs[k][3:2] !== 2'b10) begin
        failures++;
        $display("FAIL enable_scl_high cyc=%0d got=%b exp=%b", k, obs[k], {e_sda[k], e_busy[k], e_fin[k], e_err[k]});
      end
    end
  endtask
  task automatic test_enable_while_busy();
    gen(8'($urandom), 8, 12, 4, 10);
    en_s[fall_at[3]+1] = 1'b1;
    en_s[fall_at[6]+7] = 1'b1;
    play();
    model();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obs[k] !== {e_sda[k], e_busy[k], e_fin[k], e_err[k]}) begin
        failures++;
        $display("FAIL enable_while_busy cyc=%0d got=%b exp=%b", k, obs[k], {e_sda[k], e_busy[k], e_fin[k], e_err[k]});
      end
    end
  endtask
  task automatic test_abort();
    int a, fins;
    fins = 0;
    gen(8'($urandom) & 8'hF7, 8, 12, 6, 10);
    a = rise_at[4] + 2;
    ab_s[a] = 1'b1;
    play();
    model();
    for (int k = 0; k < N; k++) begin
      checks++;
      fins += int'(obs[k][1]);
      if (obs[k] !== {e_sda[k], e_busy[k], e_fin[k], e_err[k]}) begin
        failures++;
        $display("FAIL abort cyc=%0d got=%b exp=%b", k, obs[k], {e_sda[k], e_busy[k], e_fin[k], e_err[k]});
      end
    end
    checks++;
    if (obs[a][3] !== 1'b0 || obs[a+1][3:2] !== 2'b10 || fins != 0) begin
      failures++;
      $display("FAIL abort_release before=%b after=%b finishes=%0d exp 0/10/0", obs[a][3], obs[a+1][3:2], fins);
    end
  endtask
  task automatic test_readback();
    int fins;
    fins = 0;
    gen(8'hFF, 10, 10, 10, 10);
    for (int k = rise_at[2]; k < fall_at[2]; k++) sda_in_s[k] = 1'b0;
    play();
    model();
    for (int k = 0; k < N; k++) begin
      checks++;
      fins += int'(obs[k][1]);
      if (obs[k] !== {e_sda[k], e_busy[k], e_fin[k], e_err[k]}) begin
        failures++;
        $display("FAIL readback cyc=%0d got=%b exp=%b", k, obs[k], {e_sda[k], e_busy[k], e_fin[k], e_err[k]});
      end
    end
    checks++;
`ifdef I2C_SLAVE_WRITE_READBACK_CHECK_EN
    if (obs[N-1][0] !== 1'b1 || fins != 0 || obs[rise_at[2]+1][3:2] !== 2'b10) begin
      failures++;
      $display("FAIL readback_abandon error=%b finishes=%0d sda_busy=%b exp 1/0/10", obs[N-1][0], fins, obs[rise_at[2]+1][3:2]);
    end
`else
    if (obs[N-1][0] !== 1'b0 || fins != 1) begin
      failures++;
      $display("FAIL readback_ignored error=%b finishes=%0d exp 0/1", obs[N-1][0], fins);
    end
`endif
  endtask
  task automatic test_setup();
    int f;
    gen(8'($urandom), 10, 10, 10, 10);
    f = fall_at[1];
    for (int k = f + 2; k < rise_at[2]; k++) scl_s[k] = 1'b1;
    play();
    model();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obs[k] !== {e_sda[k], e_busy[k], e_fin[k], e_err[k]}) begin
        failures++;
        $display("FAIL setup cyc=%0d got=%b exp=%b", k, obs[k], {e_sda[k], e_busy[k], e_fin[k], e_err[k]});
      end
    end
    checks++;
    if (obs[f+3][3] !== dat_s[5] || obs[f+3][0] !== 1'b1 || obs[N-1][0] !== 1'b1) begin
      failures++;
      $display("FAIL setup_violation sda=%b error=%b final_error=%b exp %b/1/1", obs[f+3][3], obs[f+3][0], obs[N-1][0], dat_s[5]);
    end
  endtask
  task automatic test_setup_clear();
    gen(8'($urandom), 6, 12, 3, 10);
    play();
    model();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (obs[k] !== {e_sda[k], e_busy[k], e_fin[k], e_err[k]}) begin
        failures++;
        $display("FAIL setup_clear cyc=%0d got=%b exp=%b", k, obs[k], {e_sda[k], e_busy[k], e_fin[k], e_err[k]});
      end
    end
    checks++;
    if (obs[5][0] !== 1'b1 || obs[6][0] !== 1'b0) begin
      failures++;
      $display("FAIL setup_clear_edge error@enable=%b error@next=%b exp 1/0", obs[5][0], obs[6][0]);
    end
  endtask
  initial begin
    test_reset();
    test_a5();
    test_random();
    test_enable_scl_high();
    test_enable_while_busy();
    test_abort();
    test_setup();
    test_setup_clear();
    test_readback();
    test_setup();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_slave_write_byte.md
# i2c_slave_write_byte

Slave-side I2C byte transmitter: serialises one 8-bit byte MSB-first onto SDA during a master read, changing SDA only while SCL is low and holding it through each SCL high phase. It is the transmit counterpart of the slave byte receiver and sits under the slave controller FSM. The controller issues `enable` in the SCL-low phase after the address/ACK bit and treats the master's ACK/NACK separately after `finish`.

## Interface
- `HOLD_CYCLES`, default 4: `clock` cycles between a detected SCL falling edge (or accepted `enable`) and the SDA update (tHD;DAT); legal range 0–255.
- `clock` input, 1 bit: system clock; all logic is on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `enable` input, 1 bit: single-cycle start pulse; accepted only in IDLE with `scl`=0.
- `abort` input, 1 bit: synchronous abort. Releases SDA and returns the block to IDLE with no `finish`.
- `data` input, 8 bits: byte to send; sampled in the `enable` cycle.
- `busy` output, 1 bit: high from the cycle after an accepted `enable` until the block returns to IDLE.
- `error` output, 1 bit: sticky; cleared by `reset` or by the next accepted `enable`.
- `finish` output, 1 bit: one-cycle pulse at the SCL falling edge that ends bit 0.
- `scl` input, 1 bit: bus clock, already synchronised.
- `sda_in` input, 1 bit: bus data, already synchronised.
- `sda_out` output, 1 bit: open-drain control. 0 pulls SDA low; 1 releases it.

## Operation
- Edge detection: `scl_last` is registered and resets to 1. A falling edge is `scl_last & ~scl`; a rising edge is `~scl_last & scl`.
- States: IDLE, HOLD, DRIVEN, RELEASE.
- IDLE: `sda_out`=1. An `enable` with `scl`=0 loads `data` into the shift register, sets bit index to 7, clears `error`, loads the hold counter and moves to HOLD. `enable` while `scl`=1 or while not in IDLE is ignored.
- HOLD: the counter decrements. At expiry, `sda_out` takes shift[7] and the block moves to DRIVEN.
- HOLD, SCL rising edge before expiry: `sda_out` takes shift[7] immediately, `error` is set (setup violation), and the block moves to DRIVEN.
- DRIVEN, SCL rising edge: this is a readback event (see Configuration).
- DRIVEN, SCL falling edge with index>0: shift left, decrement the index, reload the hold counter, move to HOLD.
- DRIVEN, SCL falling edge with index=0: pulse `finish`, reload the hold counter, move to RELEASE.
- RELEASE: at counter expiry, set `sda_out`=1 and return to IDLE. SDA is now free for the master's ACK.
- Priority: `reset` > `abort` > edge events > `enable`.
- `abort` or `reset` in any state gives `sda_out`=1, `busy`=0, `finish`=0 and state IDLE on the next clock edge. `error` is kept on `abort` and cleared on `reset`.
- Wrap-around: the index never goes below 0. The shift register refills only on an accepted `enable`.

## Timing
- Reset values: `sda_out`=1, `busy`=0, `error`=0, `finish`=0, state IDLE, `scl_last`=1.
- Accepted `enable` in cycle t: `busy`=1 at t+1, `sda_out` shows bit 7 at t+HOLD_CYCLES+1.
- Falling-edge detect in cycle f: `sda_out` shows the next bit at f+HOLD_CYCLES+1.
- `finish` is high during f+1 for the last falling edge. `busy` drops at f+HOLD_CYCLES+1, together with the SDA release.
- Bit-level latency is one `clock` cycle of edge detection plus HOLD_CYCLES.
- `sda_out` never changes while `scl`=1, except on `abort` or `reset`.

## Configuration
- Macro: `I2C_SLAVE_WRITE_READBACK_CHECK_EN`.
- Defined: on each SCL rising edge in DRIVEN, if `sda_out`=1 and `sda_in`=0, `error` is set. On that mismatch the block also releases SDA and goes to IDLE without `finish`, because another device is driving the bus.
- Undefined: no readback. `error` reports only setup violations and the transfer always completes.

## Structure
- Shared package `i2c_slave_pkg` holds the state encodings, the `BIT_INDEX_W`=3 constant and the default `HOLD_CYCLES`.
- One sub-module, `i2c_slave_write_bit`, is natural. It owns the hold counter and drives one bit across a single SCL low/high period. The byte level owns the index, the shift register, `finish` and `abort`.

## Test plan
- Send `data`=8'hA5 with HOLD_CYCLES=4 and SCL at 1/20 of `clock`. Required: `sda_out` sequence 1,0,1,0,0,1,0,1; each change exactly 5 clocks after the falling-edge detect; one `finish` pulse; `sda_out`=1 afterwards.
- `enable` with `scl`=1: required `busy` stays 0 and `sda_out` stays 1.
- `abort` after bit 3's rising edge while driving 0: required `sda_out`=1 and `busy`=0 on the next clock, and no `finish`.
- Readback, with the macro defined: `data`=8'hFF, force `sda_in`=0 during bit 5's high phase. Required: `error`=1, `sda_out`=1, state IDLE, no `finish`.
  - Same stimulus without the macro: all 8 bits complete, `error`=0, `finish` pulses.
- SCL rising edge 2 clocks after a falling edge with HOLD_CYCLES=4: required `error`=1 and the bit is driven immediately.
  - A following `enable` in IDLE clears `error`.
